des_decryption_unroll8: RTL
===========================

# des_decryption_unroll8

Unrolled-by-8 DES decryption core, the inverse counterpart of the 8-round-unrolled encryption core in the DES datapath. It accepts a 64-bit ciphertext and the 16 round keys in encryption order (K1 first), and applies them in reverse (K16..K1) over two passes of an 8-stage des_roundfunction chain. It wraps the chain with ip_permutation on the input and ip_inverse_permutation on the output. It sits beside the encryption core and shares the same key-schedule output format, so one key expander serves both directions.

## Interface
- No parameters.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only in IDLE; ciphertext and round_keys must be valid in the same cycle.
- ciphertext  input  [1:64]  block to decrypt, MSB-first DES bit numbering.
- round_keys  input  [1:768]  K1 at [1:48], K2 at [49:96], …, K16 at [721:768] (encryption order).
- done  output  1  one-cycle pulse; result is valid in this cycle.
- busy  output  1  high whenever state != IDLE.
- result  output  [1:64]  registered plaintext; held until the next completed operation.

## Operation
- States: IDLE, LAUNCH, WAIT, FINISH. A 1-bit pass counter selects the pass: 0 = rounds K16..K9, 1 = rounds K8..K1.
- IDLE, start=1:
  - M <= IP(ciphertext).
  - The key register is loaded reversed: slot j (j=1..16, 48 bits each, slot 1 at [1:48]) <= K(17-j).
  - pass <= 0.
  - Go to LAUNCH.
- IDLE, start=0: stay in IDLE.
- LAUNCH:
  - Chain start is asserted for exactly this one cycle.
  - Stage i of the chain receives Kn = key register slot i (i=1..8).
  - Go to WAIT.
- WAIT, chain done=0: stay in WAIT.
- WAIT, chain done=1 with pass=0:
  - M <= {L_out, R_out}.
  - The key register shifts left by 384 bits, so slots 9..16 move to 1..8.
  - pass <= 1.
  - Go to LAUNCH.
- WAIT, chain done=1 with pass=1:
  - result <= IP⁻¹({R_out, L_out}), i.e. the final L/R swap precedes IP⁻¹.
  - Go to FINISH.
- FINISH: done=1; go to IDLE.
- start is ignored in every state except IDLE.
  - Inputs are not re-sampled mid-operation.
  - Input changes after the accepting cycle have no effect.
- Reset (any state) forces:
  - state = IDLE, pass = 0, done = 0, busy = 0, result = 64'h0.
  - The des_roundfunction instances reset via the shared rst_n.
  - An in-flight operation is abandoned and produces no done.

## Timing
- Lrf is the des_roundfunction start-to-done latency; the 8-stage chain latency is 8·Lrf.
- Cycle 0: start sampled in IDLE.
- Cycle 1: LAUNCH.
- Cycle 1+8·Lrf: chain done observed; pass-0 reload at the closing edge.
- Cycle 2+8·Lrf: LAUNCH for pass 1.
- Cycle 2+16·Lrf: chain done observed; result captured at the closing edge.
- Cycle 3+16·Lrf: FINISH; done=1 and the new result is visible.
- Total latency from the start cycle to the done cycle is 3+16·Lrf.
- The earliest next start is accepted in cycle 4+16·Lrf, when IDLE is re-entered.
- Back-to-back throughput is one block per 4+16·Lrf cycles.
- result changes only on the edge ending the final WAIT. It is stable during done and in all subsequent IDLE cycles.
- busy rises in cycle 1 and falls in cycle 4+16·Lrf.
- Reset asserted in the same cycle as start: reset wins, nothing is accepted.

## Test plan
- Known answer:
  - Stimulus: ciphertext 64'h85E813540F0AB405 with round keys of key 64'h133457799BBCDFF1.
  - Response: result 64'h0123456789ABCDEF; done for exactly 1 cycle at latency 3+16·Lrf.
- Zero key:
  - Stimulus: ciphertext 64'h8CA64DE9C1B123A7 with all-zero round_keys.
  - Response: result 64'h0000000000000000.
- Round trip:
  - Stimulus: 100 random (key, plaintext) pairs through the encryption core, then its output into this block with the same round_keys.
  - Response: every result equals the original plaintext.
- Busy protection:
  - Stimulus: pulse start with a second ciphertext/keys in cycles 1, 10 and FINISH.
  - Response: all ignored; result matches the first request only; exactly one done.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during pass 1 WAIT, release, then issue a fresh known-answer request.
  - Response: no done during the abort; result=0 after reset; the fresh request completes correctly with full latency.
- Output hold:
  - Stimulus: after a done, hold start=0 for 50 cycles while toggling ciphertext and round_keys.
  - Response: result unchanged, busy=0, done=0 throughout.

Source files
------------

// File: rtl/des_decryption_unroll8.sv
// DES block decryption: IP, two passes through an 8-stage Feistel chain keyed K16..K9 then K8..K1, final swap, IP^-1.
// Start-to-done latency is 3 + 16*Lrf cycles with Lrf = 1; start is honoured only in IDLE.

module ip_permutation (
   input  logic [1:64] din,
   output logic [1:64] dout
);
   localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
   always_comb begin
      dout = '0;
      for (int i = 1; i <= 64; i++) dout[i] = din[IP_T[i-1]];
   end
endmodule

module ip_inverse_permutation (
   input  logic [1:64] din,
   output logic [1:64] dout
);
   localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
   always_comb begin
      dout = '0;
      for (int i = 1; i <= 64; i++) dout[i] = din[FP_T[i-1]];
   end
endmodule

module des_roundfunction (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:32] l_in,
   input  logic [1:32] r_in,
   input  logic [1:48] kn,
   output logic        done,
   output logic [1:32] l_out,
   output logic [1:32] r_out
);
   localparam int E_T [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                                8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                               16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                               24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
   localparam int P_T [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
   // S1..S8, each 4 rows x 16 columns of 4-bit entries, first entry at bit 0
   localparam logic [0:2047] SBOX = {
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
      logic [1:48] x;
      logic [1:32] s;
      logic [1:32] p;
      logic [5:0]  six;
      int          idx;
      for (int i = 1; i <= 48; i++) x[i] = r[E_T[i-1]] ^ k[i];
      for (int b = 0; b < 8; b++) begin
         six = x[6*b+1 +: 6];
         idx = b * 64 + 16 * int'({six[5], six[0]}) + int'(six[4:1]);
         s[4*b+1 +: 4] = SBOX[idx*4 +: 4];
      end
      for (int i = 1; i <= 32; i++) p[i] = s[P_T[i-1]];
      return p;
   endfunction

   logic        done_q, done_d;
   logic [1:32] l_q, l_d, r_q, r_d;

   always_comb begin
      done_d = start;
      l_d    = l_q;
      r_d    = r_q;
      if (start) begin
         l_d = r_in;
         r_d = l_in ^ feistel(r_in, kn);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         l_q    <= '0;
         r_q    <= '0;
      end else begin
         done_q <= done_d;
         l_q    <= l_d;
         r_q    <= r_d;
      end
   end

   assign done  = done_q;
   assign l_out = l_q;
   assign r_out = r_q;
endmodule

module des_decryption_unroll8 (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:64]  ciphertext,
   input  logic [1:768] round_keys,
   output logic         done,
   output logic         busy,
   output logic [1:64]  result
);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

   state_t       state_q, state_d;
   logic         pass_q, pass_d;
   logic [1:64]  m_q, m_d;
   logic [1:768] key_q, key_d;
   logic [1:64]  result_q, result_d;
   logic         launch;

   logic [0:8]        st_s;
   logic [0:8][1:32]  l_s;
   logic [0:8][1:32]  r_s;
   logic [1:64]       ip_ct;
   logic [1:64]       fp_out;

   ip_permutation u_ip (.din(ciphertext), .dout(ip_ct));

   assign st_s[0] = launch;
   assign l_s[0]  = m_q[1:32];
   assign r_s[0]  = m_q[33:64];

   // stage i always consumes key slot i; the slot contents change between passes
   for (genvar g = 1; g <= 8; g++) begin : g_stage
      des_roundfunction u_rf (
         .clk   (clk),
         .rst_n (rst_n),
         .start (st_s[g-1]),
         .l_in  (l_s[g-1]),
         .r_in  (r_s[g-1]),
         .kn    (key_q[48*(g-1)+1 +: 48]),
         .done  (st_s[g]),
         .l_out (l_s[g]),
         .r_out (r_s[g])
      );
   end

   // the final swap is folded into the operand order
   ip_inverse_permutation u_fp (.din({r_s[8], l_s[8]}), .dout(fp_out));

   always_comb begin
      state_d  = state_q;
      pass_d   = pass_q;
      m_d      = m_q;
      key_d    = key_q;
      result_d = result_q;
      launch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d = ip_ct;
               for (int j = 1; j <= 16; j++)
                  key_d[48*(j-1)+1 +: 48] = round_keys[48*(16-j)+1 +: 48];
               pass_d  = 1'b0;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            launch  = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (st_s[8]) begin
               if (!pass_q) begin
                  m_d     = {l_s[8], r_s[8]};
                  key_d   = {key_q[385:768], 384'b0};
                  pass_d  = 1'b1;
                  state_d = LAUNCH;
               end else begin
                  result_d = fp_out;
                  state_d  = FINISH;
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pass_q   <= 1'b0;
         m_q      <= '0;
         key_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         pass_q   <= pass_d;
         m_q      <= m_d;
         key_q    <= key_d;
         result_q <= result_d;
      end
   end

   assign done   = (state_q == FINISH);
   assign busy   = (state_q != IDLE);
   assign result = result_q;
endmodule
